// File: rtl/enc_pack_sequencer_if.sv
// Handshake bundle between encoder control, level-HV fetch, binder packs and the bundler.
interface enc_pack_sequencer_if #(
    parameter int NUM_PACKS = 10,
    parameter int IDX_W     = $clog2(NUM_PACKS)
);
    logic                 start;
    logic                 abort;
    logic                 busy;
    logic                 lvl_req;
    logic [IDX_W-1:0]     lvl_addr;
    logic                 lvl_gnt;
    logic [NUM_PACKS-1:0] bind_start;
    logic                 out_valid;
    logic                 out_ready;
    logic [IDX_W-1:0]     out_pack_idx;
    logic                 out_last;
    logic                 done;

    modport master (
        output start, abort, lvl_gnt, out_ready,
        input  busy, lvl_req, lvl_addr, bind_start, out_valid, out_pack_idx, out_last, done
    );

    modport slave (
        input  start, abort, lvl_gnt, out_ready,
        output busy, lvl_req, lvl_addr, bind_start, out_valid, out_pack_idx, out_last, done
    );
endinterface

// File: rtl/enc_pack_sequencer.sv
// Steps through the binder packs of one sample: fetch level HVs, strobe bind, wait, emit to bundler.
// IDLE idle | FETCH level-HV request | BIND start strobe | WAIT bind latency | EMIT offer pack | DONE end pulse
module enc_pack_sequencer #(
    parameter int NUM_PACKS = 10,
    parameter int PACK_LAT  = 1,
    parameter int IDX_W     = $clog2(NUM_PACKS)
) (
    input  logic                   clk,
    input  logic                   nrst,
    enc_pack_sequencer_if.slave    bus
);
    localparam int CNT_W = (PACK_LAT > 1) ? $clog2(PACK_LAT) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_PACKS - 1);
    localparam logic [NUM_PACKS-1:0] ONE_HOT0 = NUM_PACKS'(1);
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(PACK_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_BIND, S_WAIT, S_EMIT, S_DONE} state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_lvl_req;
    logic [IDX_W-1:0]     r_lvl_addr;
    logic [NUM_PACKS-1:0] r_bind_start;
    logic                 r_out_valid;
    logic [IDX_W-1:0]     r_out_pack_idx;
    logic                 r_out_last;
    logic                 r_done;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_cnt          <= '0;
            r_busy         <= 1'b0;
            r_lvl_req      <= 1'b0;
            r_lvl_addr     <= '0;
            r_bind_start   <= '0;
            r_out_valid    <= 1'b0;
            r_out_pack_idx <= '0;
            r_out_last     <= 1'b0;
            r_done         <= 1'b0;
        end else if (bus.abort) begin
            // abort beats any handshake or start seen in the same cycle
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_cnt          <= '0;
            r_busy         <= 1'b0;
            r_lvl_req      <= 1'b0;
            r_lvl_addr     <= '0;
            r_bind_start   <= '0;
            r_out_valid    <= 1'b0;
            r_out_pack_idx <= '0;
            r_out_last     <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_FETCH;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_lvl_req  <= 1'b1;
                        r_lvl_addr <= '0;
                    end
                end
                S_FETCH: begin
                    if (bus.lvl_gnt) begin
                        r_state      <= S_BIND;
                        r_lvl_req    <= 1'b0;
                        r_lvl_addr   <= '0;
                        r_bind_start <= ONE_HOT0 << r_idx;
                    end
                end
                S_BIND: begin
                    r_bind_start <= '0;
                    r_cnt        <= CNT_LOAD;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state        <= S_EMIT;
                        r_out_valid    <= 1'b1;
                        r_out_pack_idx <= r_idx;
                        r_out_last     <= (r_idx == LAST_IDX);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        r_out_valid    <= 1'b0;
                        r_out_last     <= 1'b0;
                        r_out_pack_idx <= '0;
                        if (r_out_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx      <= r_idx + IDX_W'(1);
                            r_lvl_req  <= 1'b1;
                            r_lvl_addr <= r_idx + IDX_W'(1);
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.lvl_req      = r_lvl_req;
    assign bus.lvl_addr     = r_lvl_addr;
    assign bus.bind_start   = r_bind_start;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_pack_idx = r_out_pack_idx;
    assign bus.out_last     = r_out_last;
    assign bus.done         = r_done;
endmodule

// File: tb/tb_enc_pack_sequencer.sv
// Bench for enc_pack_sequencer: two instances (bind latency 1 and 4) against a per-pack timeline model.
module tb_enc_pack_sequencer;
    localparam int N     = 10;
    localparam int IW    = $clog2(N);
    localparam int OV_W  = 5 + 2 * IW + N;
    localparam int MAXC  = 512;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    enc_pack_sequencer_if #(.NUM_PACKS(N), .IDX_W(IW)) if0 ();
    enc_pack_sequencer_if #(.NUM_PACKS(N), .IDX_W(IW)) if1 ();

    enc_pack_sequencer #(.NUM_PACKS(N), .PACK_LAT(1), .IDX_W(IW)) u_lat1 (.clk(clk), .nrst(nrst), .bus(if0));
    enc_pack_sequencer #(.NUM_PACKS(N), .PACK_LAT(4), .IDX_W(IW)) u_lat4 (.clk(clk), .nrst(nrst), .bus(if1));

    int n_chk = 0;
    int n_err = 0;

    bit gnt_a [MAXC];
    bit rdy_a [MAXC];
    bit              e_busy  [2][MAXC];
    bit              e_req   [2][MAXC];
    logic [IW-1:0]   e_addr  [2][MAXC];
    logic [N-1:0]    e_bind  [2][MAXC];
    bit              e_valid [2][MAXC];
    logic [IW-1:0]   e_pidx  [2][MAXC];
    bit              e_last  [2][MAXC];
    bit              e_done  [2][MAXC];

    typedef struct {
        int g_lo; int g_len; int r_lo; int r_len; int exp_d0; int exp_d1;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [OV_W-1:0] mkv(bit b, bit rq, logic [IW-1:0] ad, logic [N-1:0] bs,
                                            bit v, logic [IW-1:0] pi, bit l, bit d);
        return {b, rq, ad, bs, v, pi, l, d};
    endfunction

    function automatic logic [OV_W-1:0] obs(int k);
        if (k == 0)
            return {if0.busy, if0.lvl_req, if0.lvl_addr, if0.bind_start,
                    if0.out_valid, if0.out_pack_idx, if0.out_last, if0.done};
        return {if1.busy, if1.lvl_req, if1.lvl_addr, if1.bind_start,
                if1.out_valid, if1.out_pack_idx, if1.out_last, if1.done};
    endfunction

    function automatic logic [OV_W-1:0] expv(int k, int c);
        return mkv(e_busy[k][c], e_req[k][c], e_addr[k][c], e_bind[k][c],
                   e_valid[k][c], e_pidx[k][c], e_last[k][c], e_done[k][c]);
    endfunction

    task automatic drive(input bit s, input bit a, input bit g, input bit r);
        if0.start = s;  if1.start = s;
        if0.abort = a;  if1.abort = a;
        if0.lvl_gnt = g; if1.lvl_gnt = g;
        if0.out_ready = r; if1.out_ready = r;
    endtask

    // Per pack: request from t until the first grant, bind next cycle, L wait cycles,
    // then offer until the first ready; start is taken in cycle 0.
    task automatic build(input int k, input int lat, input int ab, output int d);
        int t, g, es, e;
        logic [N-1:0] one;
        one = 1;
        for (int c = 0; c < MAXC; c++) begin
            e_busy[k][c] = 0; e_req[k][c] = 0; e_addr[k][c] = '0; e_bind[k][c] = '0;
            e_valid[k][c] = 0; e_pidx[k][c] = '0; e_last[k][c] = 0; e_done[k][c] = 0;
        end
        t = 1;
        for (int p = 0; p < N; p++) begin
            g = t;
            while (g < MAXC - 20 && !gnt_a[g]) g++;
            for (int c = t; c <= g; c++) begin
                e_req[k][c] = 1;
                e_addr[k][c] = IW'(p);
            end
            e_bind[k][g + 1] = one << p;
            es = g + 2 + lat;
            e = es;
            while (e < MAXC - 5 && !rdy_a[e]) e++;
            for (int c = es; c <= e; c++) begin
                e_valid[k][c] = 1;
                e_pidx[k][c] = IW'(p);
                e_last[k][c] = (p == N - 1);
            end
            t = e + 1;
        end
        e_done[k][t] = 1;
        for (int c = 1; c <= t; c++) e_busy[k][c] = 1;
        d = t;
        if (ab >= 0) begin
            for (int c = ab + 1; c < MAXC; c++) begin
                e_busy[k][c] = 0; e_req[k][c] = 0; e_addr[k][c] = '0; e_bind[k][c] = '0;
                e_valid[k][c] = 0; e_pidx[k][c] = '0; e_last[k][c] = 0; e_done[k][c] = 0;
            end
        end
    endtask

    task automatic run_seq(input int g_lo, input int g_len, input int r_lo, input int r_len,
                           input int ab_c, input int xs_c, input bit rnd,
                           output int d0, output int d1);
        int md0, md1, ncyc, xs, hi;
        for (int c = 0; c < MAXC; c++) begin
            if (rnd && c < 300) begin
                gnt_a[c] = ($urandom_range(0, 9) < 6);
                rdy_a[c] = ($urandom_range(0, 9) < 6);
            end else begin
                gnt_a[c] = !(c >= g_lo && c < g_lo + g_len);
                rdy_a[c] = !(c >= r_lo && c < r_lo + r_len);
            end
        end
        build(0, 1, ab_c, md0);
        build(1, 4, ab_c, md1);
        xs = xs_c;
        if (rnd) begin
            hi = (md0 < md1) ? md0 : md1;
            if (ab_c >= 0 && ab_c - 1 < hi) hi = ab_c - 1;
            xs = (hi >= 1) ? int'($urandom_range(1, hi)) : -1;
        end
        ncyc = ((md0 > md1) ? md0 : md1) + 3;
        d0 = -1;
        d1 = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                chk($sformatf("lat%0d cyc %0d outputs", (k == 0) ? 1 : 4, c), obs(k), expv(k, c));
            if (if0.done && d0 < 0) d0 = c;
            if (if1.done && d1 < 0) d1 = c;
            drive(c == 0 || c == xs, c == ab_c, gnt_a[c], rdy_a[c]);
        end
        @(negedge clk);
        drive(0, 0, 0, 0);
    endtask

    initial begin
        int d0, d1, ab;
        tbl[0] = '{g_lo: 0, g_len: 0, r_lo: 0,  r_len: 0, exp_d0: 41, exp_d1: 71};
        tbl[1] = '{g_lo: 0, g_len: 0, r_lo: 16, r_len: 5, exp_d0: 46, exp_d1: 71};
        tbl[2] = '{g_lo: 1, g_len: 4, r_lo: 0,  r_len: 0, exp_d0: 45, exp_d1: 75};
        tbl[3] = '{g_lo: 1, g_len: 4, r_lo: 20, r_len: 3, exp_d0: 48, exp_d1: 75};
        tbl[4] = '{g_lo: 0, g_len: 0, r_lo: 7,  r_len: 2, exp_d0: 42, exp_d1: 73};

        drive(0, 0, 0, 0);
        nrst = 1'b0;
        @(negedge clk);
        chk("reset lat1", obs(0), '0);
        chk("reset lat4", obs(1), '0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_seq(tbl[i].g_lo, tbl[i].g_len, tbl[i].r_lo, tbl[i].r_len, -1, -1, 0, d0, d1);
            chk($sformatf("vec%0d done cycle lat1", i), d0, tbl[i].exp_d0);
            chk($sformatf("vec%0d done cycle lat4", i), d1, tbl[i].exp_d1);
        end

        // abort with out_ready during EMIT of pack 5 (lat1), then a clean restart
        run_seq(0, 0, 0, 0, 24, -1, 0, d0, d1);
        chk("abort emit no done lat1", d0, -1);
        chk("abort emit no done lat4", d1, -1);
        run_seq(0, 0, 0, 0, -1, -1, 0, d0, d1);
        chk("restart done lat1", d0, 41);

        // abort together with start in IDLE, and a start during the DONE cycle
        run_seq(0, 0, 0, 0, 0, -1, 0, d0, d1);
        chk("abort+start ignored", d0, -1);
        run_seq(0, 0, 0, 0, -1, 41, 0, d0, d1);
        chk("start in DONE lat1", d0, 41);

        // async reset mid-WAIT of the latency-4 instance, with a start while busy
        @(negedge clk); drive(1, 0, 1, 1);
        @(negedge clk); drive(0, 0, 1, 1);
        @(negedge clk);
        @(negedge clk); drive(1, 0, 1, 1);
        @(negedge clk); drive(0, 0, 1, 1);
        chk("busy start ignored lat1", obs(0), mkv(1, 0, '0, '0, 1, '0, 0, 0));
        chk("mid wait lat4", obs(1), mkv(1, 0, '0, '0, 0, '0, 0, 0));
        #1 nrst = 1'b0;
        #1;
        chk("async reset lat1", obs(0), '0);
        chk("async reset lat4", obs(1), '0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        nrst = 1'b1;
        @(negedge clk);
        run_seq(0, 0, 0, 0, -1, -1, 0, d0, d1);
        chk("post reset done lat4", d1, 71);

        for (int r = 0; r < 8; r++) begin
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 80)) : -1;
            run_seq(0, 0, 0, 0, ab, -1, 1, d0, d1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
